// File: rtl/bullet_field.sv
// bullet_field: multi-slot bullet manager. Accepts spawns, moves every active
// slot once per game tick, then scans all slots against the player box and
// raises at most one hit or heal event per pass, followed by an
// invulnerability window.
// Build option: BULLET_FIELD_WRAP_EN -- movement wraps modulo 2^COORD_W
// instead of retiring bullets that cross the playfield edge.
//
// state | meaning
// IDLE  | waiting for a tick; only state in which spawns are accepted
// MOVE  | one slot per cycle, index 0 upward, applies velocity
// SCAN  | one slot per cycle, index 0 upward, AABB test against player
module bullet_field #(
  parameter int         NUM_BULLETS  = 8,
  parameter int         COORD_W      = 8,
  parameter logic [7:0] DAMAGE       = 8'd5,
  parameter int         INVULN_TICKS = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           enable,
  input  logic                           spawn_valid,
  output logic                           spawn_ready,
  input  logic [COORD_W-1:0]             spawn_x,
  input  logic [COORD_W-1:0]             spawn_y,
  input  logic [COORD_W-1:0]             spawn_w,
  input  logic [COORD_W-1:0]             spawn_h,
  input  logic [3:0]                     spawn_dx,
  input  logic [3:0]                     spawn_dy,
  input  logic [1:0]                     spawn_color,
  input  logic [COORD_W-1:0]             player_x,
  input  logic [COORD_W-1:0]             player_y,
  input  logic [COORD_W-1:0]             player_size,
  output logic                           hit_pulse,
  output logic [7:0]                     hit_damage,
  output logic                           heal_pulse,
  output logic                           invuln,
  output logic [NUM_BULLETS-1:0]         active_mask,
  input  logic [$clog2(NUM_BULLETS)-1:0] rd_index,
  output logic [2*COORD_W-1:0]           rd_pos,
  output logic [2*COORD_W-1:0]           rd_size,
  output logic [1:0]                     rd_color,
  output logic                           rd_active,
  output logic                           tick_overrun
);
  localparam int IW = $clog2(NUM_BULLETS);
  localparam int VW = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);
`ifdef BULLET_FIELD_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MOVE, SCAN} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]          idx, free_idx;
  logic                   last_slot, any_free, pass_start, spawn_fire;
  logic                   move_en, move_drop, overlap, take, taken;
  logic                   tick_pending;
  logic [VW-1:0]          invuln_cnt;
  logic [NUM_BULLETS-1:0] active, movable;
  logic [COORD_W-1:0]     pos_x  [NUM_BULLETS];
  logic [COORD_W-1:0]     pos_y  [NUM_BULLETS];
  logic [COORD_W-1:0]     size_w [NUM_BULLETS];
  logic [COORD_W-1:0]     size_h [NUM_BULLETS];
  logic [3:0]             vel_x  [NUM_BULLETS];
  logic [3:0]             vel_y  [NUM_BULLETS];
  logic [1:0]             color  [NUM_BULLETS];
  logic [COORD_W:0]       sum_x, sum_y, px_end, py_end, bx_end, by_end;

  // lowest free slot for the next spawn
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  // next-state logic for the pass sequencer
  always_comb begin
    state_nxt = state;
    last_slot = (idx == IW'(NUM_BULLETS - 1));
    case (state)
      IDLE:    if ((tick | tick_pending) & enable) state_nxt = MOVE;
      MOVE:    if (last_slot) state_nxt = SCAN;
      SCAN:    if (last_slot) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // movement sums and box overlap for the slot under the cursor; the extra
  // top bit catches edge crossings and keeps the compares from wrapping
  always_comb begin
    sum_x   = {1'b0, pos_x[idx]} + {{(COORD_W-3){vel_x[idx][3]}}, vel_x[idx]};
    sum_y   = {1'b0, pos_y[idx]} + {{(COORD_W-3){vel_y[idx][3]}}, vel_y[idx]};
    px_end  = {1'b0, player_x} + {1'b0, player_size};
    py_end  = {1'b0, player_y} + {1'b0, player_size};
    bx_end  = {1'b0, pos_x[idx]} + {1'b0, size_w[idx]};
    by_end  = {1'b0, pos_y[idx]} + {1'b0, size_h[idx]};
    overlap = ({1'b0, pos_x[idx]} < px_end) && ({1'b0, player_x} < bx_end) &&
              ({1'b0, pos_y[idx]} < py_end) && ({1'b0, player_y} < by_end);
  end

  assign spawn_ready = (state == IDLE) && any_free;
  assign spawn_fire  = spawn_valid && spawn_ready;
  assign pass_start  = (state == IDLE) && (state_nxt == MOVE);
  // slots spawned on the pass-start edge are left out of that pass's move
  assign move_en     = (state == MOVE) && active[idx] && movable[idx];
  assign move_drop   = !WRAP_EN && (sum_x[COORD_W] || sum_y[COORD_W]);
  assign take        = (state == SCAN) && active[idx] && overlap && !taken &&
                       (invuln_cnt == '0);
  assign invuln      = (invuln_cnt != '0);
  assign active_mask = active;

  // state register and slot cursor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) idx <= '0;
      else               idx <= last_slot ? '0 : idx + 1'b1;
    end
  end

  // slot payload: written on spawn, positions updated during MOVE
  always_ff @(posedge clk) begin
    if (spawn_fire) begin
      pos_x[free_idx]  <= spawn_x;
      pos_y[free_idx]  <= spawn_y;
      size_w[free_idx] <= spawn_w;
      size_h[free_idx] <= spawn_h;
      vel_x[free_idx]  <= spawn_dx;
      vel_y[free_idx]  <= spawn_dy;
      color[free_idx]  <= spawn_color;
    end
    if (move_en) begin
      pos_x[idx] <= sum_x[COORD_W-1:0];
      pos_y[idx] <= sum_y[COORD_W-1:0];
    end
  end

  // slot occupancy, move snapshot and per-pass take flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= '0;
      movable <= '0;
      taken   <= 1'b0;
    end else begin
      if (spawn_fire) active[free_idx] <= 1'b1;
      if (pass_start) begin
        movable <= active;
        taken   <= 1'b0;
      end
      if (move_en && move_drop) active[idx] <= 1'b0;
      if (take) begin
        active[idx] <= 1'b0;
        taken       <= 1'b1;
      end
    end
  end

  // event pulses, invulnerability down-counter, tick bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_pulse    <= 1'b0;
      hit_damage   <= 8'd0;
      heal_pulse   <= 1'b0;
      invuln_cnt   <= '0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      hit_pulse  <= take && (color[idx] == 2'd0);
      hit_damage <= (take && (color[idx] == 2'd0)) ? DAMAGE : 8'd0;
      heal_pulse <= take && (color[idx] == 2'd1);
      if (take && !color[idx][1])         invuln_cnt <= VW'(INVULN_TICKS);
      else if (pass_start && invuln)      invuln_cnt <= invuln_cnt - 1'b1;
      if (pass_start) begin
        tick_pending <= 1'b0;
      end else if (tick) begin
        if (tick_pending) tick_overrun <= 1'b1;
        tick_pending <= 1'b1;
      end
    end
  end

  // registered render read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pos    <= '0;
      rd_size   <= '0;
      rd_color  <= '0;
      rd_active <= 1'b0;
    end else if (int'(rd_index) < NUM_BULLETS) begin
      rd_pos    <= {pos_x[rd_index], pos_y[rd_index]};
      rd_size   <= {size_w[rd_index], size_h[rd_index]};
      rd_color  <= color[rd_index];
      rd_active <= active[rd_index];
    end else begin
      rd_pos    <= '0;
      rd_size   <= '0;
      rd_color  <= '0;
      rd_active <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bullet_field.sv
// Bench for bullet_field: a pass-level reference model (integer arithmetic on
// per-slot arrays) predicts occupancy, positions, events and invulnerability.
// Honours BULLET_FIELD_WRAP_EN the same way as the design.
module tb_bullet_field;
  localparam int NB  = 8;
  localparam int INV = 10;

  logic       clk = 1'b0;
  logic       reset, tick, enable, spawn_valid, spawn_ready;
  logic [7:0] spawn_x, spawn_y, spawn_w, spawn_h;
  logic [3:0] spawn_dx, spawn_dy;
  logic [1:0] spawn_color;
  logic [7:0] player_x, player_y, player_size;
  logic       hit_pulse, heal_pulse, invuln, rd_active, tick_overrun;
  logic [7:0] hit_damage;
  logic [NB-1:0] active_mask;
  logic [2:0]  rd_index;
  logic [15:0] rd_pos, rd_size;
  logic [1:0]  rd_color;

  bullet_field dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
    .spawn_dx(spawn_dx), .spawn_dy(spawn_dy), .spawn_color(spawn_color),
    .player_x(player_x), .player_y(player_y), .player_size(player_size),
    .hit_pulse(hit_pulse), .hit_damage(hit_damage), .heal_pulse(heal_pulse),
    .invuln(invuln), .active_mask(active_mask), .rd_index(rd_index),
    .rd_pos(rd_pos), .rd_size(rd_size), .rd_color(rd_color),
    .rd_active(rd_active), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hit_cnt = 0, heal_cnt = 0;
  logic [7:0] last_damage = 8'd0;

  // reference model state
  int mx[NB], my[NB], mw[NB], mh[NB], mdx[NB], mdy[NB], mc[NB];
  logic [NB-1:0] mmask;
  int minv, exp_hit, exp_heal;
  logic exp_ovr;
  int px, py, ps;

  always @(negedge clk) begin
    if (hit_pulse) begin
      hit_cnt++;
      last_damage = hit_damage;
    end
    if (heal_pulse) heal_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_player(input int x, input int y, input int s);
    px = x; py = y; ps = s;
    player_x = x[7:0]; player_y = y[7:0]; player_size = s[7:0];
  endtask

  // one spawn request in the current cycle; optional tick in the same cycle
  task automatic spawn_cycle(input int x, input int y, input int w, input int h,
                             input int dx, input int dy, input int c,
                             input bit with_tick, output int slot);
    slot = -1;
    for (int i = 0; i < NB; i++) if (!mmask[i] && slot < 0) slot = i;
    spawn_x = x[7:0]; spawn_y = y[7:0]; spawn_w = w[7:0]; spawn_h = h[7:0];
    spawn_dx = dx[3:0]; spawn_dy = dy[3:0]; spawn_color = c[1:0];
    spawn_valid = 1'b1;
    tick = with_tick;
    check_val("spawn_ready", spawn_ready, slot >= 0);
    if (slot >= 0) begin
      mx[slot] = x; my[slot] = y; mw[slot] = w; mh[slot] = h;
      mdx[slot] = dx; mdy[slot] = dy; mc[slot] = c; mmask[slot] = 1'b1;
    end
    @(negedge clk);
    spawn_valid = 1'b0;
    tick = 1'b0;
  endtask

  // whole-pass prediction: decay invuln, move everything, first overlap wins
  task automatic model_pass(input int skip);
    int nx, ny;
    bit taken;
    if (minv > 0) minv--;
    for (int s = 0; s < NB; s++) begin
      if (mmask[s] && s != skip) begin
        nx = mx[s] + mdx[s];
        ny = my[s] + mdy[s];
`ifdef BULLET_FIELD_WRAP_EN
        mx[s] = nx & 255;
        my[s] = ny & 255;
`else
        if (nx < 0 || nx > 255 || ny < 0 || ny > 255) mmask[s] = 1'b0;
        else begin
          mx[s] = nx;
          my[s] = ny;
        end
`endif
      end
    end
    taken = 1'b0;
    if (minv == 0) begin
      for (int s = 0; s < NB; s++) begin
        if (!taken && mmask[s] && mx[s] < px + ps && px < mx[s] + mw[s] &&
            my[s] < py + ps && py < my[s] + mh[s]) begin
          taken = 1'b1;
          mmask[s] = 1'b0;
          if (mc[s] == 0) exp_hit++;
          if (mc[s] == 1) exp_heal++;
          if (mc[s] < 2) minv = INV;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ":mask"}, active_mask, mmask);
    check_val({tag, ":invuln"}, invuln, minv != 0);
    check_val({tag, ":overrun"}, tick_overrun, exp_ovr);
    check_val({tag, ":hits"}, hit_cnt, exp_hit);
    check_val({tag, ":heals"}, heal_cnt, exp_heal);
    check_val({tag, ":ready"}, spawn_ready, mmask != '1);
    if (exp_hit > 0) check_val({tag, ":damage"}, last_damage, 8'd5);
    for (int s = 0; s < NB; s++) begin
      rd_index = s[2:0];
      @(negedge clk);
      check_val({tag, ":rd_active"}, rd_active, mmask[s]);
      if (mmask[s]) begin
        check_val({tag, ":rd_pos"}, rd_pos, (mx[s] << 8) | my[s]);
        check_val({tag, ":rd_size"}, rd_size, (mw[s] << 8) | mh[s]);
        check_val({tag, ":rd_color"}, rd_color, mc[s]);
      end
    end
  endtask

  task automatic do_pass(input string tag, input bit drop_en);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 2 * NB + 2; c++) begin
      if (drop_en && c == 1) enable = 1'b0;
      @(negedge clk);
    end
    enable = 1'b1;
    model_pass(-1);
    check_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mmask = '0; minv = 0; exp_ovr = 1'b0;
    check_val("reset:mask", active_mask, 0);
    check_val("reset:overrun", tick_overrun, 0);
  endtask

  initial begin
    int slot, h0, e0, n;
    reset = 1'b1; tick = 1'b0; enable = 1'b1; spawn_valid = 1'b0;
    spawn_x = 0; spawn_y = 0; spawn_w = 0; spawn_h = 0;
    spawn_dx = 0; spawn_dy = 0; spawn_color = 0; rd_index = 0;
    mmask = '0; minv = 0; exp_hit = 0; exp_heal = 0; exp_ovr = 1'b0;
    set_player(0, 200, 8);
    repeat (2) @(negedge clk);
    check_val("rst:mask", active_mask, 0);
    check_val("rst:hit", hit_pulse, 0);
    check_val("rst:heal", heal_pulse, 0);
    check_val("rst:invuln", invuln, 0);
    check_val("rst:overrun", tick_overrun, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst:ready", spawn_ready, 1);

    // fill all slots back-to-back; ninth request must stall
    set_player(0, 140, 16);
    spawn_cycle(5, 145, 2, 2, 0, 0, 2, 1'b0, slot);
    for (int i = 1; i < NB; i++) spawn_cycle(50 + i * 20, 30, 3, 3, 0, 0, i % 4, 1'b0, slot);
    spawn_cycle(200, 200, 2, 2, 0, 0, 3, 1'b0, slot);
    check_val("fill:mask", active_mask, 8'hFF);
    check_val("fill:ready", spawn_ready, 0);
    do_pass("fill_pass", 1'b0);
    spawn_cycle(200, 10, 2, 2, 0, 0, 3, 1'b0, slot);
    check_val("refill:slot", slot, 0);
    check_val("refill:mask", active_mask, 8'hFF);

    // edge crossing
    do_reset();
    set_player(0, 200, 8);
    spawn_cycle(250, 10, 2, 2, 7, 0, 2, 1'b0, slot);
    do_pass("edge", 1'b0);
`ifdef BULLET_FIELD_WRAP_EN
    check_val("edge:wrap_active", active_mask[0], 1);
    rd_index = 0;
    @(negedge clk);
    check_val("edge:wrap_x", rd_pos[15:8], 1);
`else
    check_val("edge:retired", active_mask[0], 0);
`endif

    // single damage hit and invulnerability window length
    do_reset();
    set_player(100, 100, 16);
    h0 = hit_cnt;
    spawn_cycle(110, 105, 4, 4, 0, 0, 0, 1'b0, slot);
    do_pass("hit", 1'b0);
    check_val("hit:count", hit_cnt - h0, 1);
    check_val("hit:damage", last_damage, 5);
    check_val("hit:cleared", active_mask, 0);
    check_val("hit:invuln", invuln, 1);
    for (int i = 0; i < INV - 1; i++) do_pass("inv_hold", 1'b0);
    check_val("inv:still_on", invuln, 1);
    do_pass("inv_last", 1'b0);
    check_val("inv:off", invuln, 0);

    // two overlaps: heal in slot 2 wins, damage in slot 5 survives
    do_reset();
    set_player(100, 100, 16);
    spawn_cycle(10, 10, 2, 2, 0, 0, 2, 1'b0, slot);
    spawn_cycle(20, 10, 2, 2, 0, 0, 3, 1'b0, slot);
    spawn_cycle(105, 105, 4, 4, 0, 0, 1, 1'b0, slot);
    spawn_cycle(30, 10, 2, 2, 0, 0, 2, 1'b0, slot);
    spawn_cycle(40, 10, 2, 2, 0, 0, 2, 1'b0, slot);
    spawn_cycle(108, 108, 4, 4, 0, 0, 0, 1'b0, slot);
    h0 = hit_cnt; e0 = heal_cnt;
    do_pass("dual", 1'b0);
    check_val("dual:heal", heal_cnt - e0, 1);
    check_val("dual:hit", hit_cnt - h0, 0);
    check_val("dual:slot5", active_mask[5], 1);
    check_val("dual:slot2", active_mask[2], 0);
    do_pass("dual_inv", 1'b0);
    check_val("dual_inv:hit", hit_cnt - h0, 0);
    check_val("dual_inv:slot5", active_mask[5], 1);

    // spawn and tick on the same edge: new bullet not moved this pass
    do_reset();
    set_player(0, 200, 8);
    spawn_cycle(20, 20, 2, 2, 3, 0, 2, 1'b0, slot);
    spawn_cycle(40, 20, 2, 2, 3, 0, 2, 1'b1, slot);
    repeat (2 * NB + 2) @(negedge clk);
    model_pass(slot);
    check_state("spawn_tick");

    // enable low holds a tick as pending; released when enable returns
    enable = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
    check_state("hold");
    enable = 1'b1;
    repeat (2 * NB + 3) @(negedge clk);
    model_pass(-1);
    check_state("release");

    // two ticks during MOVE: one extra pass and sticky overrun
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (4 * NB + 6) @(negedge clk);
    model_pass(-1);
    model_pass(-1);
    exp_ovr = 1'b1;
    check_state("overrun");

    // reset while SCAN has a hit queued
    do_reset();
    set_player(100, 100, 16);
    spawn_cycle(105, 105, 4, 4, 0, 0, 0, 1'b0, slot);
    h0 = hit_cnt;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (NB) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_scan:mask", active_mask, 0);
    check_val("rst_scan:invuln", invuln, 0);
    repeat (3) @(negedge clk);
    check_val("rst_scan:no_hit", hit_cnt - h0, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_scan:ready", spawn_ready, 1);
    mmask = '0; minv = 0; exp_ovr = 1'b0;

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
        spawn_cycle($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(1, 30), $urandom_range(1, 30),
                    int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                    $urandom_range(0, 3), 1'b0, slot);
      set_player($urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(8, 60));
      do_pass("rand", $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bullet_field.md
Name: bullet_field

Overview:
- Parametrised multi-bullet manager; successor to the single-bullet path (one bullet, one collision checker).
- Holds NUM_BULLETS bullet slots: spawns via valid/ready, moves each on a game tick, runs a sequential AABB scan against the player box.
- Emits hit/heal pulses into the damage path and applies an invulnerability window.
- Sits between the monster/pattern machine (spawns) and player/damage logic; the VGA renderer reads slots via a registered read port.

Parameters:
NUM_BULLETS, 8, number of bullet slots (2..32)
COORD_W, 8, coordinate/size width in bits
DAMAGE, 8'd5, value on hit_damage for a colour-0 hit
INVULN_TICKS, 10, ticks of invulnerability after any hit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle movement strobe, synchronous to clk
enable  in  1  0 = freeze movement/scan; spawns still accepted
spawn_valid  in  1  spawn request
spawn_ready  out  1  slot accepted this cycle when valid&ready
spawn_x, spawn_y  in  COORD_W each  top-left position
spawn_w, spawn_h  in  COORD_W each  size
spawn_dx, spawn_dy  in  4 each  signed velocity per tick
spawn_color  in  2  0 damage, 1 heal, 2/3 harmless
player_x, player_y  in  COORD_W each  player top-left
player_size  in  COORD_W  player square side
hit_pulse  out  1  one-cycle damage event
hit_damage  out  8  damage value, valid with hit_pulse
heal_pulse  out  1  one-cycle heal event
invuln  out  1  invulnerability window active
active_mask  out  NUM_BULLETS  slot active flags
rd_index  in  $clog2(NUM_BULLETS)  render read select
rd_pos  out  2*COORD_W  {x,y} of selected slot, 1-cycle latency
rd_size  out  2*COORD_W  {w,h}, 1-cycle latency
rd_color  out  2  colour, 1-cycle latency
rd_active  out  1  slot active, 1-cycle latency
tick_overrun  out  1  sticky: a tick arrived while one was pending

Behaviour:
- Reset (async, immediate): all slots inactive, state IDLE, outputs 0, invuln counter 0, tick_pending 0, tick_overrun 0.
- FSM IDLE -> MOVE -> SCAN -> IDLE. MOVE and SCAN take NUM_BULLETS cycles each, one slot per cycle, index 0 upward.
- IDLE: if (tick | tick_pending) & enable -> MOVE, clear tick_pending. Tick while not IDLE, or while enable=0: set tick_pending; if already set, set tick_overrun. Multiple pending ticks collapse into one.
- spawn_ready = (state==IDLE) & any slot free. Accepted spawn goes to lowest free index, active next cycle. Spawn and tick in the same IDLE cycle: spawn accepted; tick goes to MOVE the same edge; the new bullet is not moved until the next tick.
- MOVE per active slot: nx = {0,x} + sext(dx) in COORD_W+1 bits, likewise y. Carry/borrow (bit COORD_W set) -> slot deactivated. Otherwise store low COORD_W bits.
- SCAN per active slot: overlap iff bx < px+ps and px < bx+bw, and the same on y. Sums are COORD_W+1 bits (no wrap).
  - If invuln=0, take the first overlapping slot in scan order: colour 0 -> hit_pulse=1, hit_damage=DAMAGE; colour 1 -> heal_pulse=1; colours 2/3 -> no event.
  - Any overlapping slot that is taken (any colour) is deactivated. Only one event per scan; later overlaps are untouched.
  - Pulses are asserted in the cycle after the slot's compare.
- Invuln: a hit or heal loads INVULN_TICKS. Counter decrements at each IDLE->MOVE transition. invuln = (counter != 0). While invuln=1, overlaps cause no event and no deactivation.
- enable=0 mid MOVE/SCAN: the current pass completes. Only new passes are held off.
- Read port: registered, 1-cycle latency, independent of FSM. rd_index >= NUM_BULLETS returns zeros.

Optional Feature:
- Macro BULLET_FIELD_WRAP_EN.
- Defined: MOVE overflow/underflow wraps modulo 2^COORD_W; bullets never leave by edge and are removed only by collision.
- Undefined: edge overflow deactivates the slot, as above.
- SCAN is unchanged in both cases.

Test Plan:
- Reset, then spawn 8 bullets back-to-back -> spawn_ready high for 8 cycles, active_mask=8'hFF, then spawn_ready=0. The 9th request is held until a slot frees.
- Bullet (x=250,dx=+7), tick (macro undefined) -> slot deactivated after MOVE. With BULLET_FIELD_WRAP_EN -> x=1, still active.
- Player (100,100,size 16), colour-0 bullet at (110,105,4x4), tick -> exactly one hit_pulse with hit_damage=5; slot cleared; invuln=1 for 10 ticks.
- Two overlapping bullets (slots 2 colour 1, slot 5 colour 0) -> only heal_pulse from slot 2; slot 5 remains active. During invuln, next tick gives no pulse.
- Tick pulses at 3 cycles and 5 cycles after the first tick (both during MOVE) -> one extra pass after return to IDLE; tick_overrun=1.
- Assert reset during SCAN with an overlap pending -> no pulse emitted; active_mask=0 immediately; spawn_ready=1 after reset release.
